// File: rtl/data_mem_ws.sv
// Wait-state data memory for the LSU mem_* port: one request at a time, WAIT_CYCLES latency, one-cycle ready_o.
// Optional DATA_MEM_ERR_EN adds a registered err_o flagging out-of-range accesses.
module data_mem_ws #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_req_i,
  input  logic        write_enable_i,
  input  logic [3:0]  byte_enable_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        ready_o
`ifdef DATA_MEM_ERR_EN
  ,
  output logic        err_o
`endif
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state;
  logic [7:0]      cnt;
  logic            we_q;
  logic [3:0]      be_q;
  logic [AW-1:0]   idx_q;
  logic            inr_q;
  logic [31:0]     wd_q;
  logic [31:0]     mem [DEPTH];

  logic            in_range;
  logic            fire;
  logic            a_we;
  logic [3:0]      a_be;
  logic [AW-1:0]   a_idx;
  logic            a_inr;
  logic [31:0]     a_wd;

  assign in_range = (addr_i[31:AW+2] == '0);

  // With zero wait states the access fires on the accept edge itself, so
  // operands come straight from the inputs in IDLE and from the latches otherwise.
  assign fire  = (state == IDLE && mem_req_i && WAIT_CYCLES == 0) ||
                 (state == BUSY && cnt == 8'd0);
  assign a_we  = (state == IDLE) ? write_enable_i     : we_q;
  assign a_be  = (state == IDLE) ? byte_enable_i      : be_q;
  assign a_idx = (state == IDLE) ? addr_i[AW+1:2]     : idx_q;
  assign a_inr = (state == IDLE) ? in_range           : inr_q;
  assign a_wd  = (state == IDLE) ? write_data_i       : wd_q;

  // Storage is intentionally not reset; reset only blocks a pending write.
  always_ff @(posedge clk_i) begin
    if (rst_i && fire && a_we && a_inr) begin
      for (int n = 0; n < 4; n++) begin
        if (a_be[n]) mem[a_idx][8*n +: 8] <= a_wd[8*n +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      we_q        <= 1'b0;
      be_q        <= 4'd0;
      idx_q       <= '0;
      inr_q       <= 1'b0;
      wd_q        <= 32'd0;
      ready_o     <= 1'b0;
      read_data_o <= 32'd0;
`ifdef DATA_MEM_ERR_EN
      err_o       <= 1'b0;
`endif
    end else begin
      ready_o <= fire;
`ifdef DATA_MEM_ERR_EN
      err_o   <= fire && !a_inr;
`endif
      if (fire && !a_we) read_data_o <= a_inr ? mem[a_idx] : 32'd0;
      case (state)
        IDLE: begin
          if (mem_req_i) begin
            we_q  <= write_enable_i;
            be_q  <= byte_enable_i;
            idx_q <= addr_i[AW+1:2];
            inr_q <= in_range;
            wd_q  <= write_data_i;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              cnt   <= 8'(WAIT_CYCLES - 1);
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt == 8'd0) state <= RESP;
          else             cnt   <= cnt - 8'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_ws.sv
// Bench for data_mem_ws: two instances (WAIT_CYCLES=2 and 0), a transaction-level
// memory/timing model checked every cycle, plus directed literal checks.
module tb_data_mem_ws;
  localparam int DEPTH = 64;
  localparam int WS[2] = '{2, 0};
`ifdef DATA_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req[2];
  logic        we[2];
  logic [3:0]  be[2];
  logic [31:0] addr[2];
  logic [31:0] wd[2];
  logic [31:0] rdata[2];
  logic        rdy[2];
  logic        err[2];

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  data_mem_ws #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_ws2 (
    .clk_i(clk), .rst_i(rst_n), .mem_req_i(req[0]), .write_enable_i(we[0]),
    .byte_enable_i(be[0]), .addr_i(addr[0]), .write_data_i(wd[0]),
    .read_data_o(rdata[0]), .ready_o(rdy[0])
`ifdef DATA_MEM_ERR_EN
    , .err_o(err[0])
`endif
  );

  data_mem_ws #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_ws0 (
    .clk_i(clk), .rst_i(rst_n), .mem_req_i(req[1]), .write_enable_i(we[1]),
    .byte_enable_i(be[1]), .addr_i(addr[1]), .write_data_i(wd[1]),
    .read_data_o(rdata[1]), .ready_o(rdy[1])
`ifdef DATA_MEM_ERR_EN
    , .err_o(err[1])
`endif
  );

`ifndef DATA_MEM_ERR_EN
  assign err[0] = 1'b0;
  assign err[1] = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: each accept completes WAIT edges later (same edge when WAIT=0),
  // and the next accept is possible two edges after completion.
  int          ecnt = 0;
  logic        m_busy[2];
  int          m_done[2];
  int          m_free[2];
  logic        m_we[2];
  logic [3:0]  m_be[2];
  logic [31:0] m_addr[2];
  logic [31:0] m_wd[2];
  logic [31:0] mm[2][DEPTH];
  logic [3:0]  mk[2][DEPTH];
  logic [31:0] m_rd[2];
  logic        m_rdk[2];
  logic        exp_rdy[2];
  logic        exp_err[2];

  initial begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < DEPTH; j++) begin
        mm[i][j] = 32'd0;
        mk[i][j] = 4'd0;
      end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 1'b0; exp_rdy[i] = 1'b0; exp_err[i] = 1'b0;
        m_rd[i] = 32'd0; m_rdk[i] = 1'b1; m_free[i] = 0; m_done[i] = 0;
      end
    end else begin
      ecnt++;
      for (int i = 0; i < 2; i++) begin
        logic [31:0] wi;
        exp_rdy[i] = 1'b0;
        exp_err[i] = 1'b0;
        if (!m_busy[i] && ecnt >= m_free[i] && req[i]) begin
          m_busy[i] = 1'b1; m_done[i] = ecnt + WS[i];
          m_we[i] = we[i]; m_be[i] = be[i]; m_addr[i] = addr[i]; m_wd[i] = wd[i];
        end
        if (m_busy[i] && ecnt == m_done[i]) begin
          wi = m_addr[i] >> 2;
          m_busy[i] = 1'b0; m_free[i] = ecnt + 2;
          exp_rdy[i] = 1'b1;
          exp_err[i] = ERR_EN && (wi >= DEPTH);
          if (m_we[i]) begin
            if (wi < DEPTH)
              for (int n = 0; n < 4; n++)
                if (m_be[i][n]) begin
                  mm[i][wi][8*n +: 8] = m_wd[i][8*n +: 8];
                  mk[i][wi][n] = 1'b1;
                end
          end else if (wi >= DEPTH) begin
            m_rd[i] = 32'd0; m_rdk[i] = 1'b1;
          end else begin
            m_rd[i] = mm[i][wi]; m_rdk[i] = (mk[i][wi] == 4'hF);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("ready[%0d]", i), {31'd0, rdy[i]}, {31'd0, exp_rdy[i]});
        chk($sformatf("err[%0d]", i), {31'd0, err[i]}, {31'd0, exp_err[i]});
        if (m_rdk[i]) chk($sformatf("rdata[%0d]", i), rdata[i], m_rd[i]);
      end
    end
  end

  // Called at a negedge with the instance idle; returns latency in edges counting the accept edge.
  task automatic acc(input int i, input logic w, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] d, input bit scr,
                     output logic [31:0] rd, output int lat, output logic e);
    req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wd[i] = d; lat = 0;
    rd = 32'd0; e = 1'b0;
    while (lat < 50) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (scr && lat == 1) begin addr[i] = 32'h40; wd[i] = $urandom; be[i] = 4'hF; end
      if (rdy[i]) break;
    end
    chk("handshake_timeout", {31'd0, lat < 50}, 32'd1);
    rd = rdata[i]; e = err[i];
    req[i] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    int lat;
    logic e;
    int pulses;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'd0; addr[i] = 32'd0; wd[i] = 32'd0;
    end
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk("reset_ready", {31'd0, rdy[0]}, 32'd0);
    chk("reset_rdata", rdata[0], 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Full-word write then read, 3-edge latency with two wait states
    acc(0, 1'b1, 4'hF, 32'h10, 32'hA5A5_1234, 1'b0, rd, lat, e);
    chk("wr_latency", lat, 32'd3);
    acc(0, 1'b0, 4'hF, 32'h10, 32'd0, 1'b0, rd, lat, e);
    chk("rd_latency", lat, 32'd3);
    chk("rd_0x10", rd, 32'hA5A5_1234);
    chk("rd_err_inrange", {31'd0, e}, 32'd0);

    // Byte-lane merge
    acc(0, 1'b1, 4'hF, 32'h20, 32'h1122_3344, 1'b0, rd, lat, e);
    acc(0, 1'b1, 4'h1, 32'h20, 32'h0000_00FF, 1'b0, rd, lat, e);
    acc(0, 1'b0, 4'h0, 32'h20, 32'd0, 1'b0, rd, lat, e);
    chk("rd_merge", rd, 32'h1122_33FF);
    acc(0, 1'b1, 4'h6, 32'h22, 32'hAABB_CCDD, 1'b0, rd, lat, e);
    acc(0, 1'b0, 4'h0, 32'h20, 32'd0, 1'b0, rd, lat, e);
    chk("rd_mid_lanes", rd, 32'h11BB_CCFF);

    // be=0 write completes but changes nothing
    acc(0, 1'b1, 4'h0, 32'h10, 32'h0, 1'b0, rd, lat, e);
    chk("be0_latency", lat, 32'd3);
    acc(0, 1'b0, 4'hF, 32'h10, 32'd0, 1'b0, rd, lat, e);
    chk("be0_noop", rd, 32'hA5A5_1234);

    // Address change during BUSY is ignored
    acc(0, 1'b1, 4'hF, 32'h40, 32'h0BAD_F00D, 1'b0, rd, lat, e);
    acc(0, 1'b0, 4'hF, 32'h10, 32'd0, 1'b1, rd, lat, e);
    chk("addr_change", rd, 32'hA5A5_1234);

    // Reset mid-BUSY aborts the pending write
    acc(0, 1'b1, 4'hF, 32'h30, 32'h0, 1'b0, rd, lat, e);
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h30; wd[0] = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    pulses = 0;
    repeat (6) begin @(negedge clk); pulses += int'(rdy[0]); end
    chk("abort_no_ready", pulses, 32'd0);
    acc(0, 1'b0, 4'hF, 32'h30, 32'd0, 1'b0, rd, lat, e);
    chk("abort_rd_0x30", rd, 32'h0);

    // Out of range: read returns 0, write dropped (would alias word 4 otherwise)
    acc(0, 1'b0, 4'hF, 32'h100, 32'd0, 1'b0, rd, lat, e);
    chk("oor_rd_data", rd, 32'h0);
    chk("oor_latency", lat, 32'd3);
    chk("oor_err", {31'd0, e}, {31'd0, ERR_EN});
    acc(0, 1'b1, 4'hF, 32'h110, 32'hFFFF_FFFF, 1'b0, rd, lat, e);
    acc(0, 1'b0, 4'hF, 32'h10, 32'd0, 1'b0, rd, lat, e);
    chk("oor_wr_dropped", rd, 32'hA5A5_1234);

    // Zero wait states with request held: ready every 2nd cycle
    req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = 32'h8; wd[1] = 32'h0000_0055;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("ws0_pattern", {31'd0, rdy[1]}, {31'd0, (k % 2) == 0});
      pulses += int'(rdy[1]);
    end
    chk("ws0_pulses", pulses, 32'd5);
    req[1] = 1'b0;
    @(negedge clk);
    acc(1, 1'b0, 4'hF, 32'h8, 32'd0, 1'b0, rd, lat, e);
    chk("ws0_latency", lat, 32'd1);
    chk("ws0_rd", rd, 32'h0000_0055);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
